// File: rtl/instr_fetch_pkg.sv
// Shared types and instruction-field constants for the fetch/decode sequencer.
//   fetch_state_e : sequencer states
//   OP_* / FN_JR  : opcode and funct encodings recognised by the decoder
//   *_W           : instruction field widths
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DEC  = 2'd2,
    S_ERR  = 2'd3
  } fetch_state_e;

  localparam int unsigned OPC_W  = 6;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned IMM_W  = 16;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPC_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPC_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPC_W-1:0] FN_JR    = 6'b001000;

endpackage

// File: rtl/instr_decode.sv
// Combinational field decode of the instruction register.
//   instr          : instruction word
//   jmp_c/jreg_c/breq_c/brne_c : raw control-flow selects (not state-gated)
//   addr_c         : jump target field
//   sign_ext_imm_c : sign-extended 16-bit immediate
//   rs_addr_c      : rs register read address
module instr_decode
  import instr_fetch_pkg::*;
#(
  parameter int unsigned BITS = 32
) (
  input  logic [BITS-1:0]   instr,
  output logic              jmp_c,
  output logic              jreg_c,
  output logic              breq_c,
  output logic              brne_c,
  output logic [BITS-7:0]   addr_c,
  output logic [BITS-1:0]   sign_ext_imm_c,
  output logic [REG_AW-1:0] rs_addr_c
);

  logic [OPC_W-1:0] opcode;
  logic [OPC_W-1:0] funct;

  assign opcode = instr[BITS-1 -: OPC_W];
  assign funct  = instr[OPC_W-1:0];

  // Opcodes are distinct, so at most one select can be high.
  assign jmp_c  = (opcode == OP_J);
  assign breq_c = (opcode == OP_BEQ);
  assign brne_c = (opcode == OP_BNE);
  assign jreg_c = (opcode == OP_RTYPE) && (funct == FN_JR);

  assign addr_c         = instr[BITS-7:0];
  assign sign_ext_imm_c = {{(BITS-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};
  assign rs_addr_c      = instr[25:21];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch and branch-decode sequencer driving the program counter.
//   clk, rst          : clock, async active-high reset
//   run               : fetch enable, sampled in IDLE and DEC
//   pc_addr           : current instruction address
//   mem_req/mem_addr  : instruction memory read request / address
//   mem_ack/mem_rdata : read data valid / instruction word
//   instr             : instruction register
//   rs_addr, addr, sign_ext_imm : fields decoded from instr in every state
//   load_instr        : PC update strobe (DEC)
//   jmp/jreg/breq/brne: control-flow selects (DEC only)
//   fetch_err         : sticky memory-timeout flag
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned BITS    = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [BITS-1:0]   pc_addr,
  output logic              mem_req,
  output logic [BITS-1:0]   mem_addr,
  input  logic              mem_ack,
  input  logic [BITS-1:0]   mem_rdata,
  output logic [BITS-1:0]   instr,
  output logic [REG_AW-1:0] rs_addr,
  output logic              load_instr,
  output logic              jmp,
  output logic              jreg,
  output logic              breq,
  output logic              brne,
  output logic [BITS-7:0]   addr,
  output logic [BITS-1:0]   sign_ext_imm,
  output logic              fetch_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  fetch_state_e     state;
  fetch_state_e     state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_c;
  logic             accept_c;
  logic             jmp_c, jreg_c, breq_c, brne_c;

  // Last permitted wait cycle; an ack in this same cycle still wins.
  assign timeout_c = (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign accept_c  = (state == S_REQ) && mem_ack;

  instr_decode #(.BITS(BITS)) u_decode (
    .instr          (instr),
    .jmp_c          (jmp_c),
    .jreg_c         (jreg_c),
    .breq_c         (breq_c),
    .brne_c         (brne_c),
    .addr_c         (addr),
    .sign_ext_imm_c (sign_ext_imm),
    .rs_addr_c      (rs_addr)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (run) state_nxt = S_REQ;
      S_REQ: begin
        if (mem_ack)        state_nxt = S_DEC;
        else if (timeout_c) state_nxt = S_ERR;
      end
      S_DEC:   state_nxt = run ? S_REQ : S_IDLE;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs; async reset forces IDLE so mem_req drops at once.
  always_comb begin
    mem_req    = 1'b0;
    mem_addr   = '0;
    load_instr = 1'b0;
    jmp        = 1'b0;
    jreg       = 1'b0;
    breq       = 1'b0;
    brne       = 1'b0;
    case (state)
      S_REQ: begin
        mem_req  = 1'b1;
        mem_addr = pc_addr;
      end
      S_DEC: begin
        load_instr = 1'b1;
        jmp        = jmp_c;
        jreg       = jreg_c;
        breq       = breq_c;
        brne       = brne_c;
      end
      default: ;
    endcase
  end

  // Wait counter: counts unacknowledged REQ cycles, zero everywhere else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           wait_cnt <= '0;
    else if (state == S_REQ && !mem_ack) wait_cnt <= wait_cnt + CNT_W'(1);
    else                               wait_cnt <= '0;
  end

  // Instruction register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           instr <= '0;
    else if (accept_c) instr <= mem_rdata;
  end

  // Sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          fetch_err <= 1'b0;
    else if (state == S_REQ && !mem_ack && timeout_c) fetch_err <= 1'b1;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: transaction-level model compared every
// cycle, plus literal expectations at known points of each directed scenario.
module tb_instr_fetch;

  localparam int unsigned BITS    = 32;
  localparam int unsigned TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run;
  logic [31:0] pc_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic [4:0]  rs_addr;
  logic        load_instr;
  logic        jmp, jreg, breq, brne;
  logic [25:0] addr;
  logic [31:0] sign_ext_imm;
  logic        fetch_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_fetch #(.BITS(BITS), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .pc_addr      (pc_addr),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .instr        (instr),
    .rs_addr      (rs_addr),
    .load_instr   (load_instr),
    .jmp          (jmp),
    .jreg         (jreg),
    .breq         (breq),
    .brne         (brne),
    .addr         (addr),
    .sign_ext_imm (sign_ext_imm),
    .fetch_err    (fetch_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a fetch is outstanding, a word is being
  // handed to the PC, or the block has given up after TIMEOUT misses.
  logic        m_fetching, m_decoding, m_halted;
  int          m_misses;
  logic [31:0] m_instr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_fetching <= 1'b0; m_decoding <= 1'b0; m_halted <= 1'b0;
      m_misses   <= 0;    m_instr    <= 32'h0;
    end else if (m_halted) begin
      m_halted <= 1'b1;
    end else if (m_fetching) begin
      if (mem_ack) begin
        m_instr    <= mem_rdata;
        m_fetching <= 1'b0;
        m_decoding <= 1'b1;
      end else if (m_misses + 1 == int'(TIMEOUT)) begin
        m_fetching <= 1'b0;
        m_halted   <= 1'b1;
      end else begin
        m_misses <= m_misses + 1;
      end
    end else if (m_decoding) begin
      m_decoding <= 1'b0;
      m_fetching <= run;
      m_misses   <= 0;
    end else if (run) begin
      m_fetching <= 1'b1;
      m_misses   <= 0;
    end
  end

  logic [31:0] cw;
  int          cop;

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    cw  = m_instr;
    cop = int'(cw >> 26);
    chk("mem_req",    32'(mem_req),    32'(m_fetching));
    chk("mem_addr",   mem_addr,        m_fetching ? pc_addr : 32'h0);
    chk("load_instr", 32'(load_instr), 32'(m_decoding));
    chk("jmp",        32'(jmp),        32'(m_decoding && cop == 2));
    chk("breq",       32'(breq),       32'(m_decoding && cop == 4));
    chk("brne",       32'(brne),       32'(m_decoding && cop == 5));
    chk("jreg",       32'(jreg),       32'(m_decoding && cop == 0 && (cw % 64) == 8));
    chk("instr",      instr,           cw);
    chk("addr",       32'(addr),       cw % 32'd67108864);
    chk("sign_ext_imm", sign_ext_imm,  cw[15] ? (cw | 32'hFFFF_0000) : (cw & 32'h0000_FFFF));
    chk("rs_addr",    32'(rs_addr),    (cw >> 21) % 32);
    chk("fetch_err",  32'(fetch_err),  32'(m_halted));
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // One fetch from IDLE: run dropped right after entering REQ, ack after
  // `stall` wait cycles. Returns positioned mid-DEC.
  task automatic fetch(input logic [31:0] pc, input logic [31:0] data, input int stall);
    @(posedge clk); #2 run = 1'b1; pc_addr = pc; mem_ack = 1'b0;
    @(posedge clk); #2 run = 1'b0;
    for (int k = 0; k < stall; k++) begin
      #1 chk("stall_req", 32'(mem_req), 32'h1);
      chk("stall_addr", mem_addr, pc);
      @(posedge clk); #2;
    end
    #1 chk("req_req", 32'(mem_req), 32'h1);
    chk("req_addr", mem_addr, pc);
    mem_ack = 1'b1; mem_rdata = data;
    @(posedge clk); #2 mem_ack = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    #1;
  endtask

  task automatic after_dec();
    @(posedge clk); #3;
    chk("idle_req",  32'(mem_req),    32'h0);
    chk("idle_load", 32'(load_instr), 32'h0);
  endtask

  logic [31:0] rd [8];
  int          loads;

  initial begin
    run = 1'b0; pc_addr = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    rd = '{32'h0800_0100, 32'hAAAA_0000, 32'h1000_FFFF, 32'h5555_0000,
           32'h0000_0008, 32'h6666_0000, 32'h2400_0007, 32'h7777_0000};

    repeat (2) @(posedge clk); #3;
    chk("rst_req",   32'(mem_req),   32'h0);
    chk("rst_instr", instr,          32'h0);
    chk("rst_err",   32'(fetch_err), 32'h0);
    chk("rst_load",  32'(load_instr), 32'h0);
    rst = 1'b0;

    // Basic jump fetch
    fetch(32'h10, 32'h0800_0040, 0);
    chk("j_jmp",  32'(jmp),        32'h1);
    chk("j_load", 32'(load_instr), 32'h1);
    chk("j_addr", 32'(addr),       32'h40);
    chk("j_instr", instr,          32'h0800_0040);
    after_dec();

    // BEQ with negative immediate
    fetch(32'h14, 32'h1022_FFFC, 0);
    chk("beq_breq", 32'(breq),    32'h1);
    chk("beq_jmp",  32'(jmp),     32'h0);
    chk("beq_imm",  sign_ext_imm, 32'hFFFF_FFFC);
    chk("beq_rs",   32'(rs_addr), 32'd1);
    after_dec();

    // JR
    fetch(32'h18, 32'h03E0_0008, 0);
    chk("jr_jreg", 32'(jreg),    32'h1);
    chk("jr_rs",   32'(rs_addr), 32'd31);
    chk("jr_jmp",  32'(jmp),     32'h0);
    chk("jr_breq", 32'(breq),    32'h0);
    chk("jr_brne", 32'(brne),    32'h0);
    after_dec();

    // BNE with positive immediate
    fetch(32'h1C, 32'h1400_0003, 0);
    chk("bne_brne", 32'(brne),    32'h1);
    chk("bne_imm",  sign_ext_imm, 32'h3);
    after_dec();

    // Load word: sequential step, no select
    fetch(32'h20, 32'h8C00_0000, 1);
    chk("lw_load", 32'(load_instr), 32'h1);
    chk("lw_sel",  32'({jmp, jreg, breq, brne}), 32'h0);
    after_dec();

    // R-type add: funct is not JR
    fetch(32'h24, 32'h0000_0020, 0);
    chk("add_jreg", 32'(jreg), 32'h0);
    after_dec();

    // Stall 5 cycles with run dropped during the wait
    fetch(32'h28, 32'h0800_0001, 5);
    chk("stall_jmp", 32'(jmp),       32'h1);
    chk("stall_err", 32'(fetch_err), 32'h0);
    after_dec();

    // Ack on the last permitted wait cycle wins over the timeout
    fetch(32'h2C, 32'h1000_0000, 14);
    chk("edge_breq", 32'(breq),      32'h1);
    chk("edge_err",  32'(fetch_err), 32'h0);
    after_dec();

    // Back-to-back stream with ack held high; DEC-cycle data must be ignored
    @(posedge clk); #2 run = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h0;
    loads = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      mem_rdata = rd[i];
      pc_addr   = 32'h100 + 32'(4 * (i / 2));
      if (i == 7) begin run = 1'b0; mem_ack = 1'b0; end
      #1 if (load_instr) loads++;
    end
    chk("stream_loads", 32'(loads), 32'd4);
    chk("stream_instr", instr,      32'h2400_0007);
    after_dec();

    // Timeout: no ack for TIMEOUT cycles
    @(posedge clk); #2 run = 1'b1; mem_ack = 1'b0;
    @(posedge clk); #2;
    repeat (14) begin @(posedge clk); #2; end
    #1 chk("to_pre_err", 32'(fetch_err), 32'h0);
    chk("to_pre_req", 32'(mem_req), 32'h1);
    @(posedge clk); #3;
    chk("to_err",   32'(fetch_err), 32'h1);
    chk("to_req",   32'(mem_req),   32'h0);
    chk("to_instr", instr,          32'h2400_0007);
    mem_ack = 1'b1;
    repeat (3) begin
      @(posedge clk); #3;
      chk("err_req", 32'(mem_req),   32'h0);
      chk("err_err", 32'(fetch_err), 32'h1);
    end
    mem_ack = 1'b0; run = 1'b0;

    @(posedge clk); #2 rst = 1'b1;
    #1 chk("rst_clr_err", 32'(fetch_err), 32'h0);
    @(posedge clk); #2 rst = 1'b0;

    // Async reset in the middle of a REQ, late ack ignored
    fetch(32'h30, 32'h0800_0123, 0);
    after_dec();
    @(posedge clk); #2 run = 1'b1; pc_addr = 32'h40;
    @(posedge clk); #2 run = 1'b0;
    #1 chk("ar_req_before", 32'(mem_req), 32'h1);
    #1 rst = 1'b1;
    #1 chk("ar_req",   32'(mem_req),  32'h0);
    chk("ar_addr",  mem_addr,       32'h0);
    chk("ar_instr", instr,          32'h0);
    chk("ar_load",  32'(load_instr), 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2 mem_ack = 1'b0;
    #1 chk("ar_late_instr", instr, 32'h0);
    chk("ar_late_req", 32'(mem_req),   32'h0);
    chk("ar_late_err", 32'(fetch_err), 32'h0);

    repeat (2) @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
